// File: rtl/mram_serial_host_if.sv
// mram_serial_host_if: command/response handshake between a requester and the MRAM serial host.
interface mram_serial_host_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_word_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (
    output cmd_valid, cmd_write, cmd_word_sel, cmd_addr, cmd_wdata,
    input  cmd_ready, busy, rsp_valid, rsp_rdata
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_word_sel, cmd_addr, cmd_wdata,
    output cmd_ready, busy, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mram_serial_host.sv
// mram_serial_host: shifts one parallel command serially into the MRAM top and deserialises read data.
module mram_serial_host #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  mram_serial_host_if.slave   bus,
  output logic                addr_ser,
  output logic                data_ser,
  output logic [2:0]          read_write_sel,
  input  logic                ser_data_in
);
  localparam int CW = $clog2(ADDR_W + SETTLE_CYCLES + DATA_W + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, CAPTURE, DONE} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_ash, r_dsh;
  logic [DATA_W-1:0] r_cap, r_rdata;
  logic [1:0]        r_sel;
  logic              r_write, r_ready, r_busy, r_valid, r_aser, r_dser;
  logic [1:0]        w_sel;
  logic [CW-1:0]     w_lim;
  logic              w_last;
  logic [DATA_W-1:0] w_rsp;
  assign w_sel  = &bus.cmd_word_sel ? 2'b00 : bus.cmd_word_sel;
  assign w_lim  = r_state == SHIFT  ? CW'(ADDR_W - 1) :
                  r_state == SETTLE ? CW'(SETTLE_CYCLES - 1) :
                  r_sel == 2'b00    ? CW'(DATA_W - 1) : CW'(7);
  assign w_last = r_cnt == w_lim;
  // Byte reads land in the low byte of the capture register and are repositioned here.
  assign w_rsp  = r_write         ? '0 :
                  r_sel == 2'b01  ? DATA_W'(r_cap[7:0]) :
                  r_sel == 2'b10  ? DATA_W'(r_cap[7:0]) << (DATA_W - 8) : r_cap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ash   <= '0;
      r_dsh   <= '0;
      r_cap   <= '0;
      r_rdata <= '0;
      r_sel   <= 2'b00;
      r_write <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_aser  <= 1'b0;
      r_dser  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_state <= SHIFT;
          r_cnt   <= '0;
          r_ash   <= bus.cmd_addr;
          r_dsh   <= ADDR_W'(bus.cmd_wdata);
          r_write <= bus.cmd_write;
          r_sel   <= w_sel;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
        SHIFT: begin
          r_aser  <= r_ash[ADDR_W-1];
          r_dser  <= r_dsh[ADDR_W-1];
          r_ash   <= r_ash << 1;
          r_dsh   <= r_dsh << 1;
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          r_state <= w_last ? SETTLE : SHIFT;
        end
        SETTLE: begin
          r_aser  <= 1'b0;
          r_dser  <= 1'b0;
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          r_state <= !w_last ? SETTLE : r_write ? DONE : CAPTURE;
        end
        CAPTURE: begin
          r_cap   <= {r_cap[DATA_W-2:0], ser_data_in};
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          r_state <= w_last ? DONE : CAPTURE;
        end
        DONE: begin
          r_valid <= 1'b1;
          r_rdata <= w_rsp;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready  = r_ready;
  assign bus.busy       = r_busy;
  assign bus.rsp_valid  = r_valid;
  assign bus.rsp_rdata  = r_rdata;
  assign addr_ser       = r_aser;
  assign data_ser       = r_dser;
  assign read_write_sel = {r_sel, r_write};
endmodule

// File: tb/tb_mram_serial_host.sv
// tb_mram_serial_host: directed self-checking bench for mram_serial_host.
module tb_mram_serial_host;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic addr_ser, data_ser, ser_data_in;
  logic [2:0] read_write_sel;
  int checks = 0;
  int errors = 0;
  mram_serial_host_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  mram_serial_host #(.ADDR_W(20), .DATA_W(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .addr_ser(addr_ser), .data_ser(data_ser),
    .read_write_sel(read_write_sel), .ser_data_in(ser_data_in)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_cmd(input logic wr, input logic [1:0] sel, input logic [19:0] a,
                        input logic [15:0] wd, input logic [15:0] cap, input int n,
                        input int lat, input logic [15:0] exp_rd, input logic [2:0] exp_rws,
                        input int inj);
    logic [19:0] ed;
    int k;
    ed = {4'h0, wd};
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_word_sel = sel;
    bus.cmd_addr = a; bus.cmd_wdata = wd;
    tick();
    bus.cmd_valid = 1'b0;
    chk("accept_ready", 32'(bus.cmd_ready), 32'd0);
    chk("accept_busy", 32'(bus.busy), 32'd1);
    chk("accept_rws", 32'(read_write_sel), 32'(exp_rws));
    k = 0;
    while (k < 80) begin
      if (k >= 24 && k < 24 + n) ser_data_in = cap[n-1-(k-24)];
      else ser_data_in = 1'b0;
      if (inj > 0 && k == inj) begin
        bus.cmd_valid = 1'b1; bus.cmd_addr = 20'hFFFFF; bus.cmd_wdata = 16'hFFFF;
        bus.cmd_write = 1'b1; bus.cmd_word_sel = 2'b10;
      end
      if (inj > 0 && k == inj + 2) bus.cmd_valid = 1'b0;
      tick();
      k++;
      if (k <= 20) begin
        chk("addr_ser", 32'(addr_ser), 32'(a[20-k]));
        chk("data_ser", 32'(data_ser), 32'(ed[20-k]));
      end else if (k <= 24) begin
        chk("settle_ser", 32'({addr_ser, data_ser}), 32'd0);
      end
      if (bus.rsp_valid) break;
    end
    ser_data_in = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("latency", 32'(k), 32'(lat));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
    chk("done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("held_rws", 32'(read_write_sel), 32'(exp_rws));
    tick();
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("rdata_hold", 32'(bus.rsp_rdata), 32'(exp_rd));
  endtask
  initial begin
    int k;
    int seen;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_word_sel = 2'b00;
    bus.cmd_addr = '0; bus.cmd_wdata = '0; ser_data_in = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ser", 32'({addr_ser, data_ser}), 32'd0);
    chk("rst_rws", 32'(read_write_sel), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    rst = 1'b0;
    tick();
    do_cmd(1'b1, 2'b00, 20'hABCDE, 16'h1234, 16'h0000, 0, 25, 16'h0000, 3'b001, 0);
    do_cmd(1'b0, 2'b00, 20'h00001, 16'h0000, 16'hBEEF, 16, 41, 16'hBEEF, 3'b000, 0);
    do_cmd(1'b0, 2'b01, 20'h0F0F0, 16'h0000, 16'h005A, 8, 33, 16'h005A, 3'b010, 0);
    do_cmd(1'b0, 2'b10, 20'h0F0F0, 16'h0000, 16'h005A, 8, 33, 16'h5A00, 3'b100, 0);
    do_cmd(1'b0, 2'b11, 20'h55555, 16'h0000, 16'hBEEF, 16, 41, 16'hBEEF, 3'b000, 0);
    // back-to-back with cmd_valid held high
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_word_sel = 2'b00;
    bus.cmd_addr = 20'hABCDE; bus.cmd_wdata = 16'h1234;
    tick();
    chk("b2b_ready0", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_write = 1'b0; bus.cmd_addr = 20'h00001;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk("b2b_no_accept", 32'({bus.cmd_ready, bus.rsp_valid, read_write_sel}), 32'b00001);
    end
    tick();
    chk("b2b_rsp", 32'({bus.rsp_valid, bus.cmd_ready, read_write_sel}), 32'b11001);
    tick();
    chk("b2b_second", 32'({bus.rsp_valid, bus.cmd_ready, bus.busy, read_write_sel}), 32'b001000);
    bus.cmd_valid = 1'b0;
    ser_data_in = 1'b1;
    k = 0;
    while (k < 80 && !bus.rsp_valid) begin
      tick();
      k++;
    end
    ser_data_in = 1'b0;
    chk("b2b_latency", 32'(k), 32'd41);
    chk("b2b_rdata", 32'(bus.rsp_rdata), 32'h0000FFFF);
    tick();
    // reset during SHIFT cycle 7
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_word_sel = 2'b00;
    bus.cmd_addr = 20'hFFFFF; bus.cmd_wdata = 16'hFFFF;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (7) tick();
    chk("pre_rst_addr", 32'(addr_ser), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ser", 32'({addr_ser, data_ser}), 32'd0);
    chk("abort_rws", 32'(read_write_sel), 32'd0);
    chk("abort_rdata", 32'(bus.rsp_rdata), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    do_cmd(1'b1, 2'b00, 20'h3C3C3, 16'h8001, 16'h0000, 0, 25, 16'h0000, 3'b001, 0);
    // stray command during SETTLE must be ignored
    do_cmd(1'b0, 2'b00, 20'h12345, 16'h0000, 16'hC0DE, 16, 41, 16'hC0DE, 3'b000, 22);
    do_cmd(1'b1, 2'b00, 20'hA5A5A, 16'h5AA5, 16'h0000, 0, 25, 16'h0000, 3'b001, 21);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
